// File: rtl/logic_unit_pkg.sv
// Shared op-codes and the per-bit logic function for the W-bit logic unit.
// The function works on one bit, so every width W applies the scalar gate set lane by lane.
package logic_unit_pkg;

    localparam logic [2:0] OP_NAND  = 3'd0;
    localparam logic [2:0] OP_NOR   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NOTA  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    function automatic logic lu_bit(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            OP_NOTA:  r = ~a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational W-bit logic unit with zero and parity flags.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o,
    output logic         zero_o,
    output logic         parity_o
);

    logic [W-1:0] y_w;

    always_comb begin
        y_w = '0;
        for (int i = 0; i < W; i++) begin
            y_w[i] = lu_bit(op_i, a_i[i], b_i[i]);
        end
    end

    assign y_o      = y_w;
    assign zero_o   = (y_w == '0);
    assign parity_o = ^y_w;

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_core, with registered flags
// and a wrapping count of results handed to the consumer.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y,
    output logic          y_zero,
    output logic          y_parity,
    output logic [CW-1:0] count
);

    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  y_q, y_d;
    logic          zero_q, zero_d;
    logic          parity_q, parity_d;
    logic [CW-1:0] count_q, count_d;

    logic [W-1:0]  res_y;
    logic          res_zero;
    logic          res_parity;
    logic          s2_free;
    logic          s1_adv;

    // A beat moves on a handshake (valid & ready at the rising edge); a producer
    // holds valid and data until accepted. in_ready depends on out_ready and the
    // stage valids only, never on in_valid, so it drops only with both stages full.
    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;

    logic_unit_core #(.W(W)) u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .y_o      (res_y),
        .zero_o   (res_zero),
        .parity_o (res_parity)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            a_d  = a;
            b_d  = b;
            op_d = op;
        end

        // Flags are captured with y so they always describe the visible y.
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        zero_d     = zero_q;
        parity_d   = parity_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            y_d      = res_y;
            zero_d   = res_zero;
            parity_d = res_parity;
        end

        count_d = count_q;
        if (s2_valid_q && out_ready) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_NAND;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            zero_q     <= 1'b1;
            parity_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            zero_q     <= zero_d;
            parity_q   <= parity_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign y_zero    = zero_q;
    assign y_parity  = parity_q;
    assign count     = count_q;

endmodule
